// File: rtl/fifo_drain_ctrl.sv
// Drain controller for a small synchronous FIFO. It pops words once a fill threshold
// is reached, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and
// presents the words downstream on a valid/ready handshake.
module fifo_drain_ctrl #(
  parameter int DATA_W       = 4,
  parameter int CNT_W        = 4,
  parameter int START_THRESH = 4,
  parameter int STAT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  fifo_counter,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic              busy,
  output logic [STAT_W-1:0] pop_count
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(START_THRESH);

  state_t            state, state_nxt;
  logic [1:0]        occ;
  logic              infl;
  logic [DATA_W-1:0] mem0, mem1;
  logic              deq, wr;
  logic [2:0]        occ_proj;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (fifo_counter >= THRESH) state_nxt = DRAIN;
        DRAIN:   if (fifo_counter == '0 && !infl) state_nxt = IDLE;
        FLUSH:   if (!infl) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Projected skid occupancy at the edge when a read issued now would land.
  always_comb begin
    out_valid  = (occ != 2'd0);
    out_data   = out_valid ? mem0 : '0;
    busy       = (state != IDLE);
    deq        = out_valid && out_ready;
    wr         = infl && (state != FLUSH) && !flush;
    occ_proj   = {1'b0, occ} + {2'b00, infl} - {2'b00, deq};
    fifo_rd_en = (state == DRAIN) && !flush && (fifo_counter != '0) && (occ_proj < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      infl      <= 1'b0;
      mem0      <= '0;
      mem1      <= '0;
      pop_count <= '0;
    end else begin
      infl <= fifo_rd_en;
      if (deq) pop_count <= pop_count + 1'b1;
      if (flush) begin
        occ <= '0;
      end else begin
        case ({wr, deq})
          2'b10: begin
            if (occ == 2'd0) mem0 <= fifo_data;
            else             mem1 <= fifo_data;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            mem0 <= mem1;
            occ  <= occ - 2'd1;
          end
          // Write and dequeue together: the tail word shifts in behind the outgoing head.
          2'b11: begin
            if (occ == 2'd1) begin
              mem0 <= fifo_data;
            end else begin
              mem0 <= mem1;
              mem1 <= fifo_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO model, expected-word scoreboard checked
// by a negedge monitor, and directed scenarios with hand-computed expectations.
module tb_fifo_drain_ctrl;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CNT_W-1:0]  fifo_counter = '0;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd_en;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic              busy;
  logic [STAT_W-1:0] pop_count;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic rd_s, vld_s;

  fifo_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .START_THRESH(4), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .fifo_counter(fifo_counter), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .busy(busy), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // One clock: sample the settled cycle, then apply the FIFO's response to the edge.
  task automatic tick();
    #1;
    rd_s  = fifo_rd_en;
    vld_s = out_valid;
    @(posedge clk);
    #1;
    if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_counter = CNT_W'(fq.size());
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    fifo_counter = CNT_W'(fq.size());
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (n < 300 && !(fq.size() == 0 && exp_q.size() == 0 && !out_valid && !busy)) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 32'(n < 300), 1);
  endtask

  function automatic void stats(input logic [31:0] h, output int first, output int cnt,
                                output int maxrun);
    int run;
    run = 0; first = -1; cnt = 0; maxrun = 0;
    for (int i = 0; i < 32; i++) begin
      if (h[i]) begin
        cnt++;
        run++;
        if (first < 0) first = i;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  endfunction

  // Monitor: every handshake pops the scoreboard; reads on an empty FIFO are flagged.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en && fifo_counter == '0) begin
        failures++;
        $display("FAIL no_underflow: fifo_rd_en=1 with fifo_counter=0");
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0d expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_h, vld_h;
    int rf, rc, rm, vf, vc, vm;
    logic seen;

    // Reset
    tick(); tick();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop_count", pop_count, 0);
    rst = 1'b0;

    // Threshold: three words do not start draining, the fourth does
    out_ready = 1'b1;
    push(4'd1); push(4'd2); push(4'd3);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | rd_s | busy;
    end
    chk("thr_below_idle", seen, 0);
    push(4'd4);
    drain("thr");
    chk("thr_pop_count", pop_count, 4);

    // Throughput: 10 words streamed with out_ready held high
    for (int i = 0; i < 10; i++) push(DATA_W'(i + 5));
    rd_h = '0; vld_h = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      rd_h[i]  = rd_s;
      vld_h[i] = vld_s;
    end
    stats(rd_h, rf, rc, rm);
    stats(vld_h, vf, vc, vm);
    chk("tp_rd_first", rf, 1);
    chk("tp_rd_count", rc, 10);
    chk("tp_rd_run", rm, 10);
    chk("tp_vld_first", vf, 3);
    chk("tp_vld_run", vm, 10);
    drain("tp");
    chk("tp_pop_count", pop_count, 14);

    // Backpressure: only two reads fit, head word held
    out_ready = 1'b0;
    push(4'hA); push(4'hB); push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rd_s) rc++;
    end
    chk("bp_reads", rc, 2);
    chk("bp_fifo_counter", fifo_counter, 4);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 4'hA);
    tick(); tick(); tick();
    chk("bp_head_stable", out_data, 4'hA);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    drain("bp");
    chk("bp_pop_count", pop_count, 20);

    // Flush with one word buffered and one in flight
    out_ready = 1'b0;
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    tick(); tick(); tick();
    chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    chk("fl_no_read", rd_s, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_busy", busy, 1);
    chk("fl_fifo_counter", fifo_counter, 2);
    flush = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    chk("fl_idle", busy, 0);
    chk("fl_pop_count", pop_count, 20);
    push(4'd5); push(4'd6);
    out_ready = 1'b1;
    drain("fl");
    chk("fl_pop_after", pop_count, 24);

    // Simultaneous write and dequeue with one word buffered
    out_ready = 1'b0;
    push(4'd7); push(4'd8); push(4'd9); push(4'hA);
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    chk("sim_valid", out_valid, 1);
    chk("sim_head", out_data, 4'd8);
    drain("sim");
    chk("sim_pop_count", pop_count, 28);

    // Reset mid-drain with the skid buffer full
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(DATA_W'(i));
    for (int i = 0; i < 6; i++) tick();
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mr_rd_en", fifo_rd_en, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pop_count", pop_count, 0);
    rst = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_counter = '0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | vld_s | busy;
    end
    chk("mr_quiet", seen, 0);

    // Counter wrap after 256 handshakes
    out_ready = 1'b1;
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 8; i++) push(DATA_W'(b + i));
      drain("wrap");
      if (b == 30) chk("wrap_248", pop_count, 248);
    end
    chk("wrap_zero", pop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Downstream consumer of the 4-bit synchronous FIFO.
- Issues FIFO read strobes, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words to the next stage on a valid/ready handshake.
- Starts draining only once the FIFO holds a configurable number of words. Supports a flush, and keeps a count of words delivered.

Parameters:
- DATA_W, 4, data width; matches the FIFO word.
- CNT_W, 4, width of the FIFO occupancy input.
- START_THRESH, 4, FIFO occupancy at or above which draining begins.
- STAT_W, 8, width of the delivered-word counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_counter  in  CNT_W  current FIFO occupancy; already excludes pops issued in earlier cycles.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop strobe; combinational from registered state and inputs.
- out_valid  out  1  a word is available downstream.
- out_data  out  DATA_W  head word of the skid buffer.
- out_ready  in  1  downstream accepts the word this cycle.
- flush  in  1  discard buffered/in-flight words and stop reading.
- busy  out  1  state is not IDLE.
- pop_count  out  STAT_W  number of out_valid&&out_ready handshakes; wraps.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; skid occupancy occ=0; in-flight flag infl=0; pop_count=0.
  - Outputs: fifo_rd_en=0, out_valid=0, out_data=0, busy=0.
  - Reset mid-operation discards everything, including a word arriving that cycle.
- States:
  - IDLE: no reads. Go to DRAIN when fifo_counter >= START_THRESH.
  - DRAIN: reads allowed. Go to IDLE when fifo_counter==0 and infl==0; the skid buffer keeps emptying in IDLE.
  - FLUSH: no reads.
    - Entered from any state when flush=1 (flush has priority over all other transitions).
    - Stays in FLUSH while flush=1 or infl=1; then goes to IDLE.
- Read issue:
  - fifo_rd_en = (state==DRAIN) && !flush && fifo_counter!=0 && (occ + infl - deq) < 2, where deq = out_valid && out_ready.
  - The formula never overflows the skid buffer.
  - Sustains one word per cycle when out_ready is held high.
- infl is a register = fifo_rd_en of the previous cycle.
  - When infl=1 and not in FLUSH, fifo_data is written at the skid tail on that edge.
  - When infl=1 in FLUSH (or flush=1), the arriving word is dropped.
- Skid buffer:
  - 2 entries, FIFO order, occ in 0..2.
  - Simultaneous write and dequeue: occ unchanged and ordering preserved.
  - If occ==0 with a write and out_ready, the word appears the cycle after capture; no bypass, so latency from fifo_rd_en to out_valid is 2 cycles.
- Outputs:
  - out_valid = (occ!=0).
  - out_data = head entry; held stable while out_valid=1 and out_ready=0.
- flush=1: occ cleared on that edge. out_valid falls the next cycle. pop_count is not cleared.
- pop_count increments on each handshake and wraps from 2^STAT_W-1 to 0.
- Underflow: fifo_rd_en is never asserted when fifo_counter==0.
- The block never reads almostEmpty or almostFull; it uses fifo_counter only.

Test Plan:
- Threshold:
  - Reset, then FIFO loaded with 1,2,3 (counter=3) -> fifo_rd_en stays 0, busy=0.
  - Push 4 (counter=4) -> DRAIN entered; out_data sequence 1,2,3,4 with out_ready=1; pop_count=4; returns to IDLE.
- Throughput: 10 words queued, out_ready=1 -> fifo_rd_en high 10 consecutive cycles; out_valid high 10 consecutive cycles, starting 2 cycles after the first read.
- Backpressure:
  - 6 words queued, out_ready=0 -> exactly 2 reads issued; occ=2; out_data=first word held stable; fifo_counter=4.
  - Release out_ready -> remaining 4 words in order, none lost or duplicated.
- Flush with a read in flight: assert flush 1 cycle in DRAIN -> in-flight word dropped, out_valid=0 the next cycle, state IDLE one cycle after infl clears, pop_count unchanged.
- Mid-operation reset:
  - rst during DRAIN with occ=2 -> all outputs at reset values the next cycle; no out_valid until a new threshold crossing.
  - Counter wrap: 256 handshakes -> pop_count returns to 0.
- Simultaneous events, occ=1 with read arriving and out_ready=1 on the same edge -> occ stays 1; the second word becomes head.
